tile_sweep_ctrl: RTL and testbench

Sweep controller for one 8-in/8-out combinational microtile. On command it applies a selected vector sequence to the tile's `ui_in`, waits a programmable settle time, captures `uo_out`, streams each (input, output) pair and folds outputs into a 16-bit MISR signature. It sits between the shared host/scan logic and a single microtile and owns that tile's input bus while a sweep runs.

---
 rtl/tile_sweep_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_tile_sweep_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_sweep_ctrl.sv
// tile_sweep_ctrl: drives one 8-in/8-out combinational microtile through a
// selectable vector sequence. Each vector is held for SETTLE+1 cycles.
// The tile response is captured on the last edge of that window, streamed
// out as an (input, output) pair, and folded into a 16-bit MISR.
module tile_sweep_ctrl #(
    parameter int unsigned SETTLE = 2  // cycles from vector update to capture, 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic        abort,
    output logic [7:0]  tile_ui,
    input  logic [7:0]  tile_uo,
    output logic        busy,
    output logic        done,
    output logic        sample_valid,
    output logic [7:0]  sample_in,
    output logic [7:0]  sample_out,
    output logic [15:0] signature
);

    // Controller states
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StFinish = 2'd2;

    // Sequence selectors
    localparam logic [1:0] ModeExh  = 2'd0;
    localparam logic [1:0] ModeWalk = 2'd1;
    localparam logic [1:0] ModeLfsr = 2'd2;

    localparam logic [3:0]  SettleLast = SETTLE[3:0];
    localparam logic [15:0] MisrPoly   = 16'h1021;
    localparam logic [15:0] MisrSeed   = 16'hFFFF;

    logic [1:0]  state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  vidx_q, vidx_d;   // index of the vector currently applied
    logic [7:0]  tile_ui_q, tile_ui_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        sv_q, sv_d;
    logic [7:0]  sin_q, sin_d;
    logic [7:0]  sout_q, sout_d;
    logic [15:0] sig_q, sig_d;

    logic        capture;
    logic        last_vec;
    logic [15:0] misr_next;

    // First vector of a sequence; walking-one and LFSR both start at 0x01.
    function automatic logic [7:0] first_vec(input logic [1:0] m);
        logic [7:0] v;
        case (m)
            ModeExh: v = 8'h00;
            default: v = 8'h01;
        endcase
        return v;
    endfunction

    // Successor of vector v in sequence m.
    function automatic logic [7:0] next_vec(input logic [1:0] m, input logic [7:0] v);
        logic [7:0] n;
        case (m)
            ModeExh:  n = v + 8'd1;
            ModeWalk: n = {v[6:0], 1'b0};
            ModeLfsr: n = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
            default:  n = 8'h00;
        endcase
        return n;
    endfunction

    // Index of the final vector of sequence m (length minus one).
    function automatic logic [7:0] last_idx(input logic [1:0] m);
        logic [7:0] l;
        case (m)
            ModeExh:  l = 8'd255;
            ModeWalk: l = 8'd7;
            ModeLfsr: l = 8'd254;
            default:  l = 8'd0;
        endcase
        return l;
    endfunction

    // Capture strobe, end-of-sequence detect and MISR step
    always_comb begin
        capture   = (state_q == StRun) && (cnt_q == SettleLast);
        last_vec  = (vidx_q == last_idx(mode_q));
        misr_next = {sig_q[14:0], 1'b0}
                    ^ (sig_q[15] ? MisrPoly : 16'h0000)
                    ^ {8'h00, tile_uo};
    end

    // Next-state logic for the sweep sequencer and the output registers
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        vidx_d    = vidx_q;
        tile_ui_d = tile_ui_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sv_d      = 1'b0;
        sin_d     = sin_q;
        sout_d    = sout_q;
        sig_d     = sig_q;

        case (state_q)
            StIdle: begin
                // mode 3 is reserved and leaves the controller idle
                if (start && (mode != 2'd3)) begin
                    state_d   = StRun;
                    mode_d    = mode;
                    cnt_d     = 4'd0;
                    vidx_d    = 8'd0;
                    tile_ui_d = first_vec(mode);
                    busy_d    = 1'b1;
                    sig_d     = MisrSeed;
                end
            end

            StRun: begin
                if (abort) begin
                    // Abort suppresses any capture due on this edge
                    state_d   = StIdle;
                    busy_d    = 1'b0;
                    tile_ui_d = 8'h00;
                end else if (capture) begin
                    sv_d   = 1'b1;
                    sin_d  = tile_ui_q;
                    sout_d = tile_uo;
                    sig_d  = misr_next;
                    if (last_vec) begin
                        state_d   = StFinish;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        tile_ui_d = 8'h00;
                    end else begin
                        // Next vector goes out on the capture edge: no idle gap
                        tile_ui_d = next_vec(mode_q, tile_ui_q);
                        vidx_d    = vidx_q + 8'd1;
                        cnt_d     = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            StFinish: begin
                state_d = StIdle;
            end

            default: begin
                state_d   = StIdle;
                busy_d    = 1'b0;
                tile_ui_d = 8'h00;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mode_q    <= ModeExh;
            cnt_q     <= 4'd0;
            vidx_q    <= 8'd0;
            tile_ui_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sv_q      <= 1'b0;
            sin_q     <= 8'h00;
            sout_q    <= 8'h00;
            sig_q     <= MisrSeed;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            vidx_q    <= vidx_d;
            tile_ui_q <= tile_ui_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sv_q      <= sv_d;
            sin_q     <= sin_d;
            sout_q    <= sout_d;
            sig_q     <= sig_d;
        end
    end

    assign tile_ui      = tile_ui_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_valid = sv_q;
    assign sample_in    = sin_q;
    assign sample_out   = sout_q;
    assign signature    = sig_q;

endmodule

// File: tb/tb_tile_sweep_ctrl.sv
// Self-checking bench for tile_sweep_ctrl. A behavioural tile (keyed
// xor/add with optional glitches) sits on the DUT's tile bus. Expected
// vectors, captures and MISR values come from a reference model that
// works on whole sequences.
module tb_tile_sweep_ctrl;

    localparam int unsigned SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic        abort;
    logic [7:0]  tile_ui;
    logic [7:0]  tile_uo;
    logic        busy;
    logic        done;
    logic        sample_valid;
    logic [7:0]  sample_in;
    logic [7:0]  sample_out;
    logic [15:0] signature;

    logic [7:0]  key_x;
    logic [7:0]  key_a;
    logic        glitch;
    logic [7:0]  junk;

    int n_checks = 0;
    int n_errors = 0;

    tile_sweep_ctrl #(.SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode         (mode),
        .abort        (abort),
        .tile_ui      (tile_ui),
        .tile_uo      (tile_uo),
        .busy         (busy),
        .done         (done),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_out   (sample_out),
        .signature    (signature)
    );

    always #5 clk = ~clk;

    // Behavioural microtile; junk appears right after a vector change
    always_comb tile_uo = glitch ? junk : ((tile_ui ^ key_x) + key_a);

    function automatic logic [7:0] uo_of(input logic [7:0] v);
        return (v ^ key_x) + key_a;
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [7:0] d);
        logic [15:0] n;
        n = (s << 1) ^ {8'h00, d};
        if (s >= 16'h8000) n = n ^ 16'h1021;
        return n;
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Full vector list for a sequence, built from the sequence definitions
    task automatic build_seq(input int m, output logic [7:0] q[$]);
        logic [7:0] v;
        q = {};
        if (m == 0) begin
            for (int i = 0; i < 256; i++) q.push_back(8'(i));
        end else if (m == 1) begin
            for (int i = 0; i < 8; i++) q.push_back(8'(1 << i));
        end else begin
            v = 8'h01;
            for (int i = 0; i < 255; i++) begin
                q.push_back(v);
                v = {v[6:0], ^(v & 8'hB8)};
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".tile_ui"}, 16'(tile_ui), 16'h0000);
        check_eq({tag, ".busy"}, 16'(busy), 16'h0000);
        check_eq({tag, ".done"}, 16'(done), 16'h0000);
        check_eq({tag, ".sv"}, 16'(sample_valid), 16'h0000);
        check_eq({tag, ".sin"}, 16'(sample_in), 16'h0000);
        check_eq({tag, ".sout"}, 16'(sample_out), 16'h0000);
        check_eq({tag, ".sig"}, signature, 16'hFFFF);
    endtask

    // One sweep. stop_after >= 0 stops it (abort or reset) in the cycle
    // after that many sample_valid pulses.
    task automatic run_sweep(input int m, input int stop_after, input bit use_reset,
                             input bit poke, input bit abort_with_start);
        logic [7:0]  vec[$];
        logic [15:0] sig;
        int          n;
        build_seq(m, vec);
        n   = vec.size();
        sig = 16'hFFFF;

        @(negedge clk);
        start = 1'b1;
        mode  = 2'(m);
        abort = abort_with_start;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        mode  = 2'($urandom_range(3));
        check_eq("start.busy", 16'(busy), 16'h0001);
        check_eq("start.tile_ui", 16'(tile_ui), 16'(vec[0]));
        check_eq("start.done", 16'(done), 16'h0000);
        junk   = 8'($urandom);
        glitch = 1'b1;

        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < int'(SETTLE); c++) begin
                @(negedge clk);
                glitch = 1'b0;
                start  = 1'b0;
                check_eq("hold.sv", 16'(sample_valid), 16'h0000);
                check_eq("hold.tile_ui", 16'(tile_ui), 16'(vec[k]));
                if (poke && k == 1 && c == 0) begin
                    start = 1'b1;
                    mode  = 2'($urandom_range(3));
                end
                if (k == stop_after && c == 0) begin
                    if (use_reset) rst_n = 1'b0;
                    else abort = 1'b1;
                    @(negedge clk);
                    rst_n = 1'b1;
                    abort = 1'b0;
                    if (use_reset) begin
                        check_reset_vals("rst");
                    end else begin
                        check_eq("abort.busy", 16'(busy), 16'h0000);
                        check_eq("abort.tile_ui", 16'(tile_ui), 16'h0000);
                        check_eq("abort.done", 16'(done), 16'h0000);
                        check_eq("abort.sv", 16'(sample_valid), 16'h0000);
                        check_eq("abort.sig", signature, sig);
                        check_eq("abort.sin", 16'(sample_in), 16'(vec[k-1]));
                        check_eq("abort.sout", 16'(sample_out), 16'(uo_of(vec[k-1])));
                    end
                    repeat (3) begin
                        @(negedge clk);
                        check_eq("stop.quiet_done", 16'(done), 16'h0000);
                        check_eq("stop.quiet_busy", 16'(busy), 16'h0000);
                    end
                    return;
                end
            end
            @(negedge clk);
            start = 1'b0;
            sig   = misr(sig, uo_of(vec[k]));
            check_eq("cap.sv", 16'(sample_valid), 16'h0001);
            check_eq("cap.sin", 16'(sample_in), 16'(vec[k]));
            check_eq("cap.sout", 16'(sample_out), 16'(uo_of(vec[k])));
            check_eq("cap.sig", signature, sig);
            if (k == n - 1) begin
                check_eq("end.done", 16'(done), 16'h0001);
                check_eq("end.busy", 16'(busy), 16'h0000);
                check_eq("end.tile_ui", 16'(tile_ui), 16'h0000);
            end else begin
                check_eq("cap.done", 16'(done), 16'h0000);
                check_eq("cap.busy", 16'(busy), 16'h0001);
                check_eq("cap.next_ui", 16'(tile_ui), 16'(vec[k+1]));
                junk   = 8'($urandom);
                glitch = 1'b1;
            end
        end
        @(negedge clk);
        check_eq("post.done", 16'(done), 16'h0000);
        check_eq("post.busy", 16'(busy), 16'h0000);
        check_eq("post.sv", 16'(sample_valid), 16'h0000);
        check_eq("post.sig", signature, sig);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        mode   = 2'd0;
        abort  = 1'b0;
        glitch = 1'b0;
        junk   = 8'h00;
        key_x  = 8'h00;
        key_a  = 8'h00;

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("idle");

        // Reserved mode is ignored
        start = 1'b1;
        mode  = 2'd3;
        @(negedge clk);
        start = 1'b0;
        check_eq("mode3.busy", 16'(busy), 16'h0000);
        check_eq("mode3.tile_ui", 16'(tile_ui), 16'h0000);
        @(negedge clk);
        check_eq("mode3.busy2", 16'(busy), 16'h0000);

        // Abort while idle does nothing
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("idle_abort.busy", 16'(busy), 16'h0000);
        check_eq("idle_abort.sig", signature, 16'hFFFF);

        // Walking-one with uo = ~ui
        key_x = 8'hFF;
        key_a = 8'h00;
        run_sweep(1, -1, 1'b0, 1'b0, 1'b0);

        // Exhaustive with uo = ui, mid-sweep start poke, abort alongside start
        key_x = 8'h00;
        key_a = 8'h00;
        run_sweep(0, -1, 1'b0, 1'b1, 1'b1);
        check_eq("exh.tile_ui_after", 16'(tile_ui), 16'h0000);

        // LFSR with a random tile function
        key_x = 8'($urandom);
        key_a = 8'($urandom);
        run_sweep(2, -1, 1'b0, 1'b0, 1'b0);

        // Abort after four captures of an exhaustive sweep
        run_sweep(0, 4, 1'b0, 1'b0, 1'b0);

        // Reset mid-sweep, then a clean sweep
        run_sweep(2, 4, 1'b1, 1'b0, 1'b0);
        run_sweep(1, -1, 1'b0, 1'b0, 1'b0);

        // Randomised sweeps
        for (int r = 0; r < 4; r++) begin
            key_x = 8'($urandom);
            key_a = 8'($urandom);
            run_sweep(int'($urandom_range(2)), (r == 3) ? int'($urandom_range(7, 1)) : -1,
                      1'b0, 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
